// File: rtl/kt_comm_pkg.sv
// kt_comm_pkg: shared types and constants for the knight-side command link.
package kt_comm_pkg;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam int DEF_BAUD_DIV = 434;
  localparam int DEF_BYTE_TIMEOUT = 20000;
endpackage

// File: rtl/uart_byte_xcvr.sv
// uart_byte_xcvr: RX synchroniser and 8N1 byte receiver plus independent 8N1 TX shifter.
module uart_byte_xcvr
  import kt_comm_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_rx_rdy,
  output logic [7:0] o_rx_data,
  output logic       o_frm_err,
  output logic       o_rx_idle,
  input  logic [7:0] i_tx_data,
  input  logic       i_trmt,
  output logic       o_tx_busy,
  output logic       o_tx_done
);
  localparam int CW = $clog2(BAUD_DIV);
  logic r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t r_rx_st, w_rx_nxt;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic r_rx_rdy, r_frm_err;
  logic w_fall, w_half, w_full, w_rx_tick;
  tx_state_t r_tx_st, w_tx_nxt;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0] r_tx_bit;
  logic [9:0] r_tx_shift;
  logic r_tx_done;
  logic w_tx_full, w_tx_last;

  always_ff @(posedge clk or posedge rst)
    if (rst) {r_rx_s1, r_rx_s2, r_rx_prev} <= 3'b111;
    else {r_rx_s1, r_rx_s2, r_rx_prev} <= {i_rx, r_rx_s1, r_rx_s2};

  // START is entered one clock after the synchronised edge, so the half-bit compare is one short
  assign w_fall = r_rx_prev & ~r_rx_s2;
  assign w_half = r_rx_cnt == CW'(BAUD_DIV / 2 - 2);
  assign w_full = r_rx_cnt == CW'(BAUD_DIV - 1);
  assign w_rx_tick = (r_rx_st == RX_START) ? w_half : (r_rx_st != RX_IDLE) && w_full;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_rx_st <= RX_IDLE;
    else r_rx_st <= w_rx_nxt;

  always_comb begin
    w_rx_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE:  w_rx_nxt = w_fall ? RX_START : RX_IDLE;
      RX_START: w_rx_nxt = !w_half ? RX_START : r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  w_rx_nxt = (w_full && r_rx_bit == 3'd7) ? RX_STOP : RX_DATA;
      RX_STOP:  w_rx_nxt = w_full ? RX_IDLE : RX_STOP;
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_shift <= '0;
      r_rx_rdy <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_rx_rdy <= 1'b0;
      r_frm_err <= 1'b0;
      r_rx_cnt <= (r_rx_st == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      if (r_rx_st == RX_DATA && w_rx_tick) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
      if (r_rx_st == RX_STOP && w_rx_tick) begin
        r_rx_rdy <= r_rx_s2;
        r_frm_err <= ~r_rx_s2;
      end
    end

  assign o_rx_rdy = r_rx_rdy;
  assign o_frm_err = r_frm_err;
  assign o_rx_data = r_rx_shift;
  assign o_rx_idle = r_rx_st == RX_IDLE;

  assign w_tx_full = r_tx_cnt == CW'(BAUD_DIV - 1);
  assign w_tx_last = w_tx_full && r_tx_bit == 4'd9;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_tx_st <= TX_IDLE;
    else r_tx_st <= w_tx_nxt;

  always_comb
    w_tx_nxt = (r_tx_st == TX_IDLE) ? (i_trmt ? TX_SHIFT : TX_IDLE) : (w_tx_last ? TX_IDLE : TX_SHIFT);

  // The shifter refills with ones, so the line idles high once the stop bit has gone out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tx_shift <= '1;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= (r_tx_st == TX_SHIFT) && w_tx_last;
      if (r_tx_st == TX_IDLE) begin
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
        if (i_trmt) r_tx_shift <= {1'b1, i_tx_data, 1'b0};
      end else begin
        r_tx_cnt <= w_tx_full ? '0 : r_tx_cnt + CW'(1);
        if (w_tx_full) begin
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          r_tx_bit <= r_tx_bit + 4'd1;
        end
      end
    end

  assign o_tx = r_tx_shift[0];
  assign o_tx_busy = r_tx_st == TX_SHIFT;
  assign o_tx_done = r_tx_done;
endmodule

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: assembles two received bytes into a 16-bit command and sends byte responses.
module uart_cmd_responder
  import kt_comm_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV,
  parameter int BYTE_TIMEOUT = DEF_BYTE_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_busy,
  output logic        tx_done
);
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  asm_state_t r_st, w_nxt;
  logic [TW-1:0] r_tcnt;
  logic [15:0] r_cmd;
  logic r_cmd_rdy;
  logic w_rx_rdy, w_frm_err, w_rx_idle;
  logic [7:0] w_rx_data;
  logic w_timeout, w_ld_hi, w_ld_lo;

  uart_byte_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
    .clk       (clk),
    .rst       (rst),
    .i_rx      (RX),
    .o_tx      (TX),
    .o_rx_rdy  (w_rx_rdy),
    .o_rx_data (w_rx_data),
    .o_frm_err (w_frm_err),
    .o_rx_idle (w_rx_idle),
    .i_tx_data (resp),
    .i_trmt    (trmt),
    .o_tx_busy (tx_busy),
    .o_tx_done (tx_done)
  );

  assign w_timeout = (r_st == WAIT_LOW) && w_rx_idle && r_tcnt == TW'(BYTE_TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= WAIT_HIGH;
    else r_st <= w_nxt;

  always_comb
    w_nxt = w_frm_err ? WAIT_HIGH :
            (r_st == WAIT_HIGH) ? (w_rx_rdy ? WAIT_LOW : WAIT_HIGH) :
            (w_rx_rdy || w_timeout) ? WAIT_HIGH : WAIT_LOW;

  always_comb begin
    w_ld_hi = w_rx_rdy && r_st == WAIT_HIGH;
    w_ld_lo = w_rx_rdy && r_st == WAIT_LOW;
  end

  // A new low byte sets ready even if the consumer clears it in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tcnt <= '0;
      r_cmd <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      r_tcnt <= (r_st == WAIT_HIGH) ? '0 : w_rx_idle ? r_tcnt + TW'(1) : r_tcnt;
      if (w_ld_hi) r_cmd[15:8] <= w_rx_data;
      if (w_ld_lo) r_cmd[7:0] <= w_rx_data;
      r_cmd_rdy <= w_ld_lo | (r_cmd_rdy & ~(clr_cmd_rdy | w_ld_hi));
    end

  assign cmd = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: randomized remote-side stimulus checked every cycle against an event-level model.
module tb_uart_cmd_responder;
  import kt_comm_pkg::*;
  localparam int B = 16;
  localparam int TO = 400;

  logic clk = 0, rst = 1, RX = 1, clr_cmd_rdy = 0, trmt = 0;
  logic [7:0] resp = '0;
  logic TX, cmd_rdy, tx_busy, tx_done;
  logic [15:0] cmd;

  uart_cmd_responder #(.BAUD_DIV(B), .BYTE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit chk_en = 0, rx_fin = 0;

  typedef struct {int start; int due; logic [7:0] b; bit ok;} rx_ev_t;
  rx_ev_t rxq[$];
  int clrq[$];
  bit m_low = 0, m_rdy = 0;
  logic [15:0] m_cmd = '0;
  int m_hi_due = 0;
  int tx_start = -1000;
  logic [7:0] tx_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic tx_bit(input logic [7:0] b, input int idx);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[idx];
  endfunction

  // Bytes take effect one clock after their stop-bit sample; commands assemble high then low
  function automatic void step_model();
    bit set_r, clr_r;
    set_r = 0;
    clr_r = 0;
    while (rxq.size() > 0 && rxq[0].due < cyc) begin
      rx_ev_t e;
      e = rxq.pop_front();
      if (!e.ok) m_low = 0;
      else begin
        if (m_low && e.start - m_hi_due > TO) m_low = 0;
        if (!m_low) begin
          m_cmd[15:8] = e.b;
          m_low = 1;
          m_hi_due = e.due;
          clr_r = 1;
        end else begin
          m_cmd[7:0] = e.b;
          m_low = 0;
          set_r = 1;
        end
      end
    end
    while (clrq.size() > 0 && clrq[0] <= cyc) begin
      if (clrq[0] == cyc) clr_r = 1;
      void'(clrq.pop_front());
    end
    m_rdy = set_r | (m_rdy & ~clr_r);
  endfunction

  initial begin
    int k;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        step_model();
        k = cyc - tx_start;
        check("cmd", cmd, m_cmd);
        check("cmd_rdy", cmd_rdy, m_rdy);
        check("TX", TX, (k >= 0 && k < 10 * B) ? tx_bit(tx_b, k / B) : 1'b1);
        check("tx_busy", tx_busy, k >= 0 && k < 10 * B);
        check("tx_done", tx_done, k == 10 * B);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit ok);
    logic [9:0] f;
    rx_ev_t e;
    f = {ok, b, 1'b0};
    e.start = cyc;
    e.due = cyc + 2 + 19 * B / 2;
    e.b = b;
    e.ok = ok;
    rxq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
    RX = 1;
    if (!ok) repeat (B) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] w, input int gap);
    send_byte(w[15:8], 1);
    repeat (gap) @(negedge clk);
    send_byte(w[7:0], 1);
  endtask

  task automatic pulse_trmt(input logic [7:0] b);
    trmt = 1;
    resp = b;
    if (!(cyc - tx_start >= 0 && cyc - tx_start < 10 * B)) begin
      tx_start = cyc + 1;
      tx_b = b;
    end
    @(negedge clk);
    trmt = 0;
    resp = 8'($urandom);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1;
    clrq.push_back(cyc + 1);
    @(negedge clk);
    clr_cmd_rdy = 0;
  endtask

  task automatic tx_literal();
    logic [9:0] wave;
    int n, done_at;
    wave = 10'b1101001010;
    n = cyc;
    done_at = -1;
    pulse_trmt(POS_ACK);
    for (int j = 1; j <= 200; j++) begin
      if (j >= 9 && (j - 9) % B == 0 && (j - 9) / B < 10) check("tx_wave", TX, wave[(j - 9) / B]);
      if (tx_done && done_at < 0) done_at = cyc;
      @(negedge clk);
    end
    check("tx_done_latency", done_at - (n + 1), 160);
  endtask

  task automatic rx_rand();
    int mode;
    for (int i = 0; i < 25; i++) begin
      mode = $urandom_range(0, 9);
      send_byte(8'($urandom), 1);
      if (mode == 0) repeat ($urandom_range(480, 550)) @(negedge clk);
      else repeat ($urandom_range(0, 250)) @(negedge clk);
      send_byte(8'($urandom), mode != 1);
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    rx_fin = 1;
  endtask

  task automatic tx_rand();
    while (!rx_fin) begin
      @(negedge clk);
      if ((cyc - tx_start == 10 * B && $urandom_range(0, 1) == 1) || $urandom_range(0, 59) == 0)
        pulse_trmt(8'($urandom));
    end
  endtask

  task automatic clr_rand();
    while (!rx_fin) begin
      repeat ($urandom_range(50, 400)) @(negedge clk);
      pulse_clr();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_TX", TX, 1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_done", tx_done, 0);
    rst = 0;
    chk_en = 1;
    repeat (5) @(negedge clk);
    send_cmd(16'h57F4, 0);
    check("cmd_57F4", cmd, 16'h57F4);
    check("rdy_57F4", cmd_rdy, 1);
    pulse_clr();
    repeat (2) @(negedge clk);
    check("rdy_cleared", cmd_rdy, 0);
    check("cmd_held", cmd, 16'h57F4);
    tx_literal();
    send_byte(8'h5B, 1);
    repeat (500) @(negedge clk);
    send_cmd(16'h1234, 0);
    check("cmd_after_timeout", cmd, 16'h1234);
    send_byte(8'hAA, 1);
    send_byte(8'h77, 0);
    check("rdy_after_frame_err", cmd_rdy, 0);
    send_cmd(16'h5004, 0);
    check("cmd_after_frame_err", cmd, 16'h5004);
    RX = 0;
    repeat (4) @(negedge clk);
    RX = 1;
    repeat (40) @(negedge clk);
    send_cmd(16'h093C, 3);
    check("cmd_after_glitch", cmd, 16'h093C);
    fork
      send_cmd(16'hC33C, 0);
      begin repeat (100) @(negedge clk); pulse_trmt(8'h5A); end
    join
    repeat (100) @(negedge clk);
    check("cmd_overlap", cmd, 16'hC33C);
    fork rx_rand(); tx_rand(); clr_rand(); join
    repeat (400) @(negedge clk);
    send_cmd(16'hBEEF, 10);
    check("pre_rst_rdy", cmd_rdy, 1);
    pulse_trmt(POS_ACK);
    repeat (50) @(negedge clk);
    chk_en = 0;
    rst = 1;
    #1;
    check("midtx_rst_TX", TX, 1);
    check("midtx_rst_busy", tx_busy, 0);
    check("midtx_rst_rdy", cmd_rdy, 0);
    check("midtx_rst_cmd", cmd, 16'h0000);
    rxq.delete();
    clrq.delete();
    m_low = 0;
    m_rdy = 0;
    m_cmd = '0;
    tx_start = -1000;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    fork send_cmd(16'h1357, 0); pulse_trmt(8'h3C); join
    repeat (200) @(negedge clk);
    check("cmd_post_rst", cmd, 16'h1357);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Knight-side endpoint of the remote command link. Receives 16-bit commands sent by the remote (high byte first) as two 8N1 UART bytes and presents them to the command processor with a `cmd_rdy` flag. Transmits the single-byte response (e.g. positive ack 8'hA5) back on request. Sits between the `RX`/`TX` pins and the command processor inside `KnightsTour`.

## Interface
- `BAUD_DIV`, default 434: clocks per bit (50 MHz / 115200); must be ≥ 8.
- `BYTE_TIMEOUT`, default 20000: clocks allowed between the end of the high byte and the start of the low byte before resync.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `RX`  in  1  serial in from remote, idle high, asynchronous to `clk`.
- `TX`  out  1  serial out to remote, idle high.
- `cmd`  out  16  last assembled command, `{high_byte, low_byte}`.
- `cmd_rdy`  out  1  level; a complete command is valid on `cmd`.
- `clr_cmd_rdy`  in  1  single-cycle pulse from the consumer; clears `cmd_rdy`.
- `resp`  in  8  response byte, sampled on `trmt`.
- `trmt`  in  1  single-cycle pulse; start transmitting `resp`.
- `tx_busy`  out  1  transmitter active.
- `tx_done`  out  1  single-cycle pulse at the end of a transmission.

## Operation
- RX path: `RX` is synchronised with two flops, preset to 1 on reset. A falling edge in IDLE starts a byte. The start bit is re-checked at BAUD_DIV/2; if `RX` is high there, this is a glitch and the receiver returns to IDLE. Data bits are sampled LSB first every BAUD_DIV clocks after that point. The stop bit is sampled the same way. Stop = 0 is a framing error: the byte is discarded and the assembly FSM is reset to WAIT_HIGH.
- Assembly FSM, states WAIT_HIGH, WAIT_LOW:
  - WAIT_HIGH: on a good byte, store it in `cmd[15:8]`, clear `cmd_rdy`, go to WAIT_LOW and start the timeout counter.
  - WAIT_LOW: on a good byte, store it in `cmd[7:0]`, set `cmd_rdy`, go to WAIT_HIGH.
  - WAIT_LOW: if the counter reaches BYTE_TIMEOUT with no start bit detected, go to WAIT_HIGH. `cmd` and `cmd_rdy` are untouched.
- The timeout counter runs only in WAIT_LOW while the receiver is idle, and clears on entry to WAIT_LOW.
- `cmd_rdy` clears on `clr_cmd_rdy`, or on acceptance of a new high byte. If the set and the clear happen in the same cycle, set wins.
- TX path: on `trmt` while idle, latch `resp` and shift out 10 bits: start 0, 8 data bits LSB first, stop 1. Each bit lasts BAUD_DIV clocks. `trmt` while `tx_busy` is ignored.
- RX and TX are fully independent and may run simultaneously.
- Reset values: `TX`=1, `cmd`=16'h0000, `cmd_rdy`=0, `tx_busy`=0, `tx_done`=0. FSM in WAIT_HIGH, receiver in IDLE, counters 0.
- Reset asserted mid-byte abandons the byte in either direction. `TX` returns high immediately.

## Timing
- RX latency: `cmd_rdy` rises 1 clk after the low byte's stop-bit sample point. That point is 9.5·BAUD_DIV clocks after the synchronised start edge, plus 2 sync clocks.
- TX: `TX` goes low and `tx_busy` rises the clk after `trmt`.
- The stop bit lasts a full BAUD_DIV. `tx_done` pulses and `tx_busy` falls in the same clk, 10·BAUD_DIV clocks after `TX` went low.
- A new `trmt` is accepted in the cycle `tx_done` is high, giving back-to-back bytes with no idle gap.
- The receiver accepts a new start edge in the cycle after the stop-bit sample, so back-to-back bytes are received.

## Structure
- Shared package `kt_comm_pkg`: assembly-state enum, rx/tx bit-state enums, `POS_ACK = 8'hA5`, default BAUD_DIV.
- Sub-module `uart_byte_xcvr`: synchroniser, RX byte receiver (`rx_rdy`, `rx_data`, `frm_err`) and TX shifter. It is instantiated once. The top level holds the assembly FSM, the timeout counter and the `cmd`/`cmd_rdy` registers.

## Test plan
All scenarios use BAUD_DIV=16, BYTE_TIMEOUT=400, and the RemoteComm model as the far end.
- Remote sends 16'h57F4: `cmd`=16'h57F4 and `cmd_rdy`=1 at stop-sample+1. `clr_cmd_rdy` pulse → `cmd_rdy`=0, `cmd` holds.
- `trmt` with `resp`=8'hA5: `TX` waveform is 0,1,0,1,0,0,1,0,1,1 at 16 clk/bit. `tx_done` pulses exactly 160 clk after the start bit. Remote shows `resp_rdy` with `resp`=8'hA5.
- Send high byte 8'h5B, wait 500 clk, then send 8'h12, 8'h34: `cmd`=16'h1234. Byte 8'h5B never appears in `cmd[7:0]`.
- Low byte with stop bit forced 0: no `cmd_rdy`. The next two good bytes 8'h50, 8'h04 give `cmd`=16'h5004.
- 4-clk low glitch on `RX`: no byte accepted, FSM stays in WAIT_HIGH.
- Command reception and `trmt` overlapping, plus `rst` asserted mid-TX: both directions complete correctly when overlapped. On reset, `TX`=1, `tx_busy`=0, `cmd_rdy`=0 within the same cycle.
